// File: rtl/register_file_writeback_if.sv
// Write-back / decode-stage bus of the MIPS register file.
// The decode stage (master) drives the read indices and the write-back
// request; the register file (slave) returns read data and the write count.
interface register_file_writeback_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] raddr_a;
  logic [ADDR_WIDTH-1:0] raddr_b;
  logic [DATA_WIDTH-1:0] rdata_a;
  logic [DATA_WIDTH-1:0] rdata_b;
  logic [7:0]            wr_count;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b, wr_count
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b, wr_count
  );
endinterface

// File: rtl/register_file_writeback.sv
// 2**ADDR_WIDTH x DATA_WIDTH MIPS general-purpose register file.
// One write-back port fanned out through a one-hot write-enable decoder,
// two independent combinational read ports, $0 hardwired to zero, and a
// saturating count of committed writes for debug.
module register_file_writeback #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  register_file_writeback_if.slave bus
);

  localparam int unsigned NREG = 2 ** ADDR_WIDTH;

  // Register 0 is never stored; entry 0 of the array is a constant zero.
  logic [DATA_WIDTH-1:0] r_regs [NREG];
  logic [NREG-1:1]       w_wen;
  logic                  w_commit;
  logic [7:0]            r_wr_count;
  logic                  w_fwd_a;
  logic                  w_fwd_b;
  logic [DATA_WIDTH-1:0] w_rdata_a;
  logic [DATA_WIDTH-1:0] w_rdata_b;

  // One-hot write-enable decode; index 0 has no enable so $0 writes vanish.
  always_comb begin
    w_wen = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (bus.we && (bus.waddr == ADDR_WIDTH'(i))) begin
        w_wen[i] = 1'b1;
      end
    end
  end

  assign w_commit  = |w_wen;
  assign r_regs[0] = '0;

  // Storage: each nonzero register loads write-back data when selected.
  for (genvar g = 1; g < NREG; g++) begin : g_reg
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_regs[g] <= '0;
      end else if (w_wen[g]) begin
        r_regs[g] <= bus.wdata;
      end
    end
  end

  // Committed-write counter, saturating at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_count <= '0;
    end else if (w_commit && (r_wr_count != '1)) begin
      r_wr_count <= r_wr_count + 8'd1;
    end
  end

  // Forwarding is held off during reset so both ports read zero throughout.
  assign w_fwd_a = (BYPASS != 0) && reset_n && w_commit && (bus.waddr == bus.raddr_a);
  assign w_fwd_b = (BYPASS != 0) && reset_n && w_commit && (bus.waddr == bus.raddr_b);

  // Read port A: zero index reads zero, else forwarded or stored value.
  always_comb begin
    w_rdata_a = '0;
    if (bus.raddr_a != '0) begin
      w_rdata_a = w_fwd_a ? bus.wdata : r_regs[bus.raddr_a];
    end
  end

  // Read port B: resolved independently of port A.
  always_comb begin
    w_rdata_b = '0;
    if (bus.raddr_b != '0) begin
      w_rdata_b = w_fwd_b ? bus.wdata : r_regs[bus.raddr_b];
    end
  end

  assign bus.rdata_a  = w_rdata_a;
  assign bus.rdata_b  = w_rdata_b;
  assign bus.wr_count = r_wr_count;

endmodule

// File: tb/tb_register_file_writeback.sv
// Directed bench for register_file_writeback: one instance with forwarding,
// one without, driven with identical stimulus.
module tb_register_file_writeback;

  logic clk;
  logic reset_n;
  int   nvec;
  int   nerr;

  register_file_writeback_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_byp ();
  register_file_writeback_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_nob ();

  register_file_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut_byp (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_byp.slave)
  );

  register_file_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut_nob (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_nob.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply the same inputs to both instances.
  task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb);
    bus_byp.we = we; bus_byp.waddr = wa; bus_byp.wdata = wd;
    bus_byp.raddr_a = ra; bus_byp.raddr_b = rb;
    bus_nob.we = we; bus_nob.waddr = wa; bus_nob.wdata = wd;
    bus_nob.raddr_a = ra; bus_nob.raddr_b = rb;
  endtask

  // Commit one write across a clock edge; returns #1 after the edge with we=0.
  task automatic do_write(input logic [4:0] wa, input logic [31:0] wd);
    set_in(1'b1, wa, wd, 5'd0, 5'd0);
    @(posedge clk); #1;
    set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    #3;
    nvec++;
    if (bus_byp.rdata_a !== 32'h0 || bus_byp.wr_count !== 8'd0) begin
      nerr++;
      $display("FAIL reset_init: rdata_a=%h wr_count=%0d want 0/0", bus_byp.rdata_a, bus_byp.wr_count);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_write(5'd5, 32'hDEADBEEF);
    set_in(1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    #1;
    nvec++;
    if (bus_byp.rdata_a !== 32'hDEADBEEF || bus_byp.wr_count !== 8'd1) begin
      nerr++;
      $display("FAIL reset_prewrite: rdata_a=%h wr_count=%0d want deadbeef/1", bus_byp.rdata_a, bus_byp.wr_count);
    end
    // Asynchronous clear between edges, with a matching write pending.
    #1 reset_n = 1'b0;
    set_in(1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd5);
    #1;
    nvec++;
    if (bus_byp.rdata_a !== 32'h0 || bus_byp.rdata_b !== 32'h0 || bus_byp.wr_count !== 8'd0) begin
      nerr++;
      $display("FAIL reset_async: rdata_a=%h rdata_b=%h wr_count=%0d want 0/0/0",
               bus_byp.rdata_a, bus_byp.rdata_b, bus_byp.wr_count);
    end
    // Hold reset across an edge with the write asserted: write is lost.
    @(posedge clk); #1;
    reset_n = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    #1;
    nvec++;
    if (bus_byp.rdata_a !== 32'h0 || bus_nob.rdata_b !== 32'h0 || bus_byp.wr_count !== 8'd0) begin
      nerr++;
      $display("FAIL reset_write_lost: byp_a=%h nob_b=%h wr_count=%0d want 0/0/0",
               bus_byp.rdata_a, bus_nob.rdata_b, bus_byp.wr_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_write(5'd7, 32'h12345678);
    set_in(1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
    #1;
    nvec++;
    if (bus_byp.rdata_a !== 32'h12345678 || bus_byp.rdata_b !== 32'h12345678 ||
        bus_nob.rdata_a !== 32'h12345678 || bus_byp.wr_count !== 8'd1) begin
      nerr++;
      $display("FAIL basic_rw: a=%h b=%h nob_a=%h wr_count=%0d want 12345678 x3 / 1",
               bus_byp.rdata_a, bus_byp.rdata_b, bus_nob.rdata_a, bus_byp.wr_count);
    end
  endtask

  task automatic test_zero();
    set_in(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    nvec++;
    if (bus_byp.rdata_a !== 32'h0) begin
      nerr++;
      $display("FAIL zero_bypass: rdata_a=%h want 00000000", bus_byp.rdata_a);
    end
    @(posedge clk); #1;
    set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    #1;
    nvec++;
    if (bus_byp.rdata_a !== 32'h0 || bus_nob.rdata_b !== 32'h0 || bus_byp.wr_count !== 8'd1) begin
      nerr++;
      $display("FAIL zero_write: a=%h nob_b=%h wr_count=%0d want 0/0/1",
               bus_byp.rdata_a, bus_nob.rdata_b, bus_byp.wr_count);
    end
  endtask

  task automatic test_bypass();
    do_write(5'd9, 32'h11111111);
    set_in(1'b1, 5'd9, 32'h22222222, 5'd7, 5'd9);
    #1;
    nvec++;
    if (bus_byp.rdata_b !== 32'h22222222 || bus_byp.rdata_a !== 32'h12345678) begin
      nerr++;
      $display("FAIL bypass_on: b=%h a=%h want 22222222/12345678", bus_byp.rdata_b, bus_byp.rdata_a);
    end
    nvec++;
    if (bus_nob.rdata_b !== 32'h11111111) begin
      nerr++;
      $display("FAIL bypass_off_pre: b=%h want 11111111", bus_nob.rdata_b);
    end
    @(posedge clk); #1;
    set_in(1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
    #1;
    nvec++;
    if (bus_nob.rdata_b !== 32'h22222222 || bus_nob.rdata_a !== 32'h22222222 ||
        bus_byp.rdata_b !== 32'h22222222 || bus_byp.wr_count !== 8'd3) begin
      nerr++;
      $display("FAIL bypass_post: nob_b=%h nob_a=%h byp_b=%h wr_count=%0d want 22222222 x3 / 3",
               bus_nob.rdata_b, bus_nob.rdata_a, bus_byp.rdata_b, bus_byp.wr_count);
    end
  endtask

  task automatic test_onehot();
    pulse_reset();
    do_write(5'd1, 32'hA);
    do_write(5'd2, 32'hB);
    do_write(5'd31, 32'hC);
    set_in(1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
    #1;
    nvec++;
    if (bus_byp.rdata_a !== 32'hA || bus_byp.rdata_b !== 32'hB) begin
      nerr++;
      $display("FAIL onehot_r1r2: a=%h b=%h want a/b", bus_byp.rdata_a, bus_byp.rdata_b);
    end
    set_in(1'b0, 5'd0, 32'd0, 5'd30, 5'd31);
    #1;
    nvec++;
    if (bus_nob.rdata_a !== 32'h0 || bus_nob.rdata_b !== 32'hC || bus_byp.wr_count !== 8'd3) begin
      nerr++;
      $display("FAIL onehot_r30r31: a=%h b=%h wr_count=%0d want 0/c/3",
               bus_nob.rdata_a, bus_nob.rdata_b, bus_byp.wr_count);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      do_write(5'd3, 32'(i));
      if (i == 250) begin
        nvec++;
        if (bus_byp.wr_count !== 8'd254) begin
          nerr++;
          $display("FAIL sat_pre: wr_count=%0d want 254", bus_byp.wr_count);
        end
      end
    end
    set_in(1'b0, 5'd0, 32'd0, 5'd3, 5'd1);
    #1;
    nvec++;
    if (bus_byp.wr_count !== 8'd255 || bus_nob.wr_count !== 8'd255) begin
      nerr++;
      $display("FAIL sat_count: byp=%0d nob=%0d want 255", bus_byp.wr_count, bus_nob.wr_count);
    end
    nvec++;
    if (bus_byp.rdata_a !== 32'h12B || bus_byp.rdata_b !== 32'hA) begin
      nerr++;
      $display("FAIL sat_data: r3=%h r1=%h want 0000012b/0000000a", bus_byp.rdata_a, bus_byp.rdata_b);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_basic();
    test_zero();
    test_bypass();
    test_onehot();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
